// File: rtl/alu_issue_stage.sv
// Issue/collect stage wrapped around the combinational ALU units (subtractor, nand_gate, starting_ones).
// Registers operands and select, waits SETTLE cycles, then captures the muxed unit result and offers it downstream.
`timescale 1ns/1ps
module alu_issue_stage #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1,
   parameter int CNTW   = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd_op,
   input  logic [WIDTH-1:0] i_cmd_a,
   input  logic [WIDTH-1:0] i_cmd_b,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [1:0]       o_op,
   input  logic [WIDTH-1:0] i_y,
   input  logic             i_overflow,
   input  logic             i_err,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [WIDTH-1:0] o_res_y,
   output logic             o_res_overflow,
   output logic             o_res_err,
   output logic [1:0]       o_res_op,
   output logic             o_busy,
   input  logic             i_clr_status,
   output logic [CNTW-1:0]  o_ovf_cnt,
   output logic             o_err_sticky
);

   localparam int SCW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [1:0] OP_RSVD = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [SCW-1:0]   settle_cnt;
   logic             cmd_acc;
   logic             res_hs;
   logic             capture;
   logic [WIDTH-1:0] cap_y;
   logic             cap_ovf;
   logic             cap_err;
   logic             ovf_event;
   logic             err_event;
   logic [CNTW-1:0]  ovf_cnt_nxt;
   logic             err_sticky_nxt;

   assign o_busy = (state != IDLE);

   // Ready looks through to i_res_ready in RESP so a drained result and a new command share one edge.
   always_comb begin
      state_nxt   = state;
      capture     = 1'b0;
      o_cmd_ready = (state == IDLE) || ((state == RESP) && i_res_ready);
      cmd_acc     = i_cmd_valid && o_cmd_ready;
      res_hs      = o_res_valid && i_res_ready;
      case (state)
         IDLE: begin
            if (cmd_acc) state_nxt = EXEC;
         end
         EXEC: begin
            if (settle_cnt == SCW'(1)) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (res_hs) state_nxt = cmd_acc ? EXEC : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cap_y   = i_y;
      cap_ovf = i_overflow;
      cap_err = i_err;
      if (o_op == OP_RSVD) begin
         cap_y   = '0;
         cap_ovf = 1'b0;
         cap_err = 1'b1;
      end
   end

   // A clear coinciding with a counting handshake keeps that handshake's event.
   always_comb begin
      ovf_event      = res_hs && o_res_overflow;
      err_event      = res_hs && o_res_err;
      ovf_cnt_nxt    = o_ovf_cnt;
      err_sticky_nxt = o_err_sticky;
      if (i_clr_status) begin
         ovf_cnt_nxt    = ovf_event ? CNTW'(1) : '0;
         err_sticky_nxt = err_event;
      end else begin
         if (ovf_event && (o_ovf_cnt != '1)) ovf_cnt_nxt = o_ovf_cnt + CNTW'(1);
         if (err_event) err_sticky_nxt = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= IDLE;
         settle_cnt     <= '0;
         o_a            <= '0;
         o_b            <= '0;
         o_op           <= '0;
         o_res_valid    <= 1'b0;
         o_res_y        <= '0;
         o_res_overflow <= 1'b0;
         o_res_err      <= 1'b0;
         o_res_op       <= '0;
         o_ovf_cnt      <= '0;
         o_err_sticky   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cmd_acc) begin
            o_a        <= i_cmd_a;
            o_b        <= i_cmd_b;
            o_op       <= i_cmd_op;
            settle_cnt <= SCW'(SETTLE);
         end else if (state == EXEC) begin
            settle_cnt <= settle_cnt - SCW'(1);
         end
         if (capture) begin
            o_res_valid    <= 1'b1;
            o_res_y        <= cap_y;
            o_res_overflow <= cap_ovf;
            o_res_err      <= cap_err;
            o_res_op       <= o_op;
         end else if (res_hs) begin
            o_res_valid <= 1'b0;
         end
         o_ovf_cnt    <= ovf_cnt_nxt;
         o_err_sticky <= err_sticky_nxt;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: two instances (SETTLE=1 and SETTLE=3) share one stimulus bus and are each
// checked every cycle against a transaction-level model, plus literal checks of the directed cases.
`timescale 1ns/1ps
module tb_alu_issue_stage;
   localparam int W    = 4;
   localparam int CNTW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic [1:0]   cmd_op = 2'd0;
   logic [W-1:0] cmd_a = '0;
   logic [W-1:0] cmd_b = '0;
   logic         res_ready = 1'b0;
   logic         clr_status = 1'b0;

   logic            cmd_ready [2];
   logic [W-1:0]    da [2];
   logic [W-1:0]    db [2];
   logic [1:0]      dop [2];
   logic [W-1:0]    uy [2];
   logic            uovf [2];
   logic            uerr [2];
   logic            rv [2];
   logic [W-1:0]    ry [2];
   logic            rovf [2];
   logic            rerr [2];
   logic [1:0]      rop [2];
   logic            busy [2];
   logic [CNTW-1:0] ocnt [2];
   logic            sticky [2];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Stand-in for the external units; starting_ones is replaced by an arbitrary but fixed mapping.
   function automatic logic [5:0] unit_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] y;
      logic ov;
      ov = 1'b0;
      case (op)
         2'd0: begin
            y  = a - b;
            ov = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
         end
         2'd1: y = ~(a & b);
         2'd2: y = 4'($countones(a & b) << 1);
         default: begin
            y  = a ^ b;
            ov = 1'b1;
         end
      endcase
      return {y, ov, 1'b0};
   endfunction

   function automatic logic [5:0] exp_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (op == 2'd3) return {4'h0, 1'b0, 1'b1};
      return unit_fn(op, a, b);
   endfunction

   function automatic int settle_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   assign {uy[0], uovf[0], uerr[0]} = unit_fn(dop[0], da[0], db[0]);
   assign {uy[1], uovf[1], uerr[1]} = unit_fn(dop[1], da[1], db[1]);

   alu_issue_stage #(.WIDTH(W), .SETTLE(1), .CNTW(CNTW)) u_s1 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready[0]),
      .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
      .o_a(da[0]), .o_b(db[0]), .o_op(dop[0]),
      .i_y(uy[0]), .i_overflow(uovf[0]), .i_err(uerr[0]),
      .o_res_valid(rv[0]), .i_res_ready(res_ready), .o_res_y(ry[0]),
      .o_res_overflow(rovf[0]), .o_res_err(rerr[0]), .o_res_op(rop[0]),
      .o_busy(busy[0]), .i_clr_status(clr_status), .o_ovf_cnt(ocnt[0]), .o_err_sticky(sticky[0])
   );

   alu_issue_stage #(.WIDTH(W), .SETTLE(3), .CNTW(CNTW)) u_s3 (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready[1]),
      .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b),
      .o_a(da[1]), .o_b(db[1]), .o_op(dop[1]),
      .i_y(uy[1]), .i_overflow(uovf[1]), .i_err(uerr[1]),
      .o_res_valid(rv[1]), .i_res_ready(res_ready), .o_res_y(ry[1]),
      .o_res_overflow(rovf[1]), .o_res_err(rerr[1]), .o_res_op(rop[1]),
      .o_busy(busy[1]), .i_clr_status(clr_status), .o_ovf_cnt(ocnt[1]), .o_err_sticky(sticky[1])
   );

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   // Transaction model: a command is in flight for SETTLE edges, then its result is held until taken.
   int           m_left [2];
   bit           m_rv [2];
   logic [W-1:0] m_a [2];
   logic [W-1:0] m_b [2];
   logic [1:0]   m_op [2];
   logic [W-1:0] m_ry [2];
   bit           m_rovf [2];
   bit           m_rerr [2];
   logic [1:0]   m_rop [2];
   int           m_cnt [2];
   bit           m_sticky [2];

   function automatic bit exp_ready(input int d);
      return (m_left[d] == 0 && !m_rv[d]) || (m_rv[d] && res_ready);
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         bit hs;
         bit acc;
         logic [5:0] r;
         if (rst) begin
            chk_en      = 1'b1;
            m_left[d]   = 0;
            m_rv[d]     = 1'b0;
            m_a[d]      = '0;
            m_b[d]      = '0;
            m_op[d]     = '0;
            m_ry[d]     = '0;
            m_rovf[d]   = 1'b0;
            m_rerr[d]   = 1'b0;
            m_rop[d]    = '0;
            m_cnt[d]    = 0;
            m_sticky[d] = 1'b0;
         end else begin
            hs  = m_rv[d] && res_ready;
            acc = cmd_valid && exp_ready(d);
            if (clr_status) begin
               m_cnt[d]    = (hs && m_rovf[d]) ? 1 : 0;
               m_sticky[d] = hs && m_rerr[d];
            end else begin
               if (hs && m_rovf[d] && m_cnt[d] < (1 << CNTW) - 1) m_cnt[d]++;
               if (hs && m_rerr[d]) m_sticky[d] = 1'b1;
            end
            if (hs) m_rv[d] = 1'b0;
            if (m_left[d] > 0) begin
               m_left[d]--;
               if (m_left[d] == 0) begin
                  r = exp_fn(m_op[d], m_a[d], m_b[d]);
                  {m_ry[d], m_rovf[d], m_rerr[d]} = r;
                  m_rop[d] = m_op[d];
                  m_rv[d]  = 1'b1;
               end
            end
            if (acc) begin
               m_a[d]    = cmd_a;
               m_b[d]    = cmd_b;
               m_op[d]   = cmd_op;
               m_left[d] = settle_of(d);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            chk("cmd_ready", d, 32'(cmd_ready[d]), 32'(exp_ready(d)));
            chk("o_a", d, 32'(da[d]), 32'(m_a[d]));
            chk("o_b", d, 32'(db[d]), 32'(m_b[d]));
            chk("o_op", d, 32'(dop[d]), 32'(m_op[d]));
            chk("res_valid", d, 32'(rv[d]), 32'(m_rv[d]));
            chk("res_y", d, 32'(ry[d]), 32'(m_ry[d]));
            chk("res_overflow", d, 32'(rovf[d]), 32'(m_rovf[d]));
            chk("res_err", d, 32'(rerr[d]), 32'(m_rerr[d]));
            chk("res_op", d, 32'(rop[d]), 32'(m_rop[d]));
            chk("busy", d, 32'(busy[d]), 32'(m_left[d] > 0 || m_rv[d]));
            chk("ovf_cnt", d, 32'(ocnt[d]), 32'(m_cnt[d]));
            chk("err_sticky", d, 32'(sticky[d]), 32'(m_sticky[d]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a command until the SETTLE=1 instance takes it; returns just after the accepting edge.
   task automatic send0(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok;
      ok        = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready[0]) ok = 1'b1;
      end
      if (!ok) timeout_fail("send0");
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic recv0();
      bit ok;
      ok        = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (rv[0]) ok = 1'b1;
      end
      if (!ok) timeout_fail("recv0");
      tick();
      res_ready = 1'b0;
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      summary();
      $fatal(1, "watchdog expired");
   end

   initial begin
      int last_t;
      int n_res;
      repeat (2) tick();
      rst = 1'b0;
      chk("reset_res_valid", 0, 32'(rv[0]), 32'h0);
      chk("reset_cmd_ready", 0, 32'(cmd_ready[0]), 32'h1);
      chk("reset_busy", 0, 32'(busy[0]), 32'h0);
      chk("reset_ovf_cnt", 0, 32'(ocnt[0]), 32'h0);
      chk("reset_o_a", 0, 32'(da[0]), 32'h0);

      // SUB 3-5
      send0(2'd0, 4'd3, 4'd5);
      chk("sub_pending_valid", 0, 32'(rv[0]), 32'h0);
      chk("sub_busy", 0, 32'(busy[0]), 32'h1);
      chk("sub_o_a", 0, 32'(da[0]), 32'h3);
      tick();
      chk("sub_valid", 0, 32'(rv[0]), 32'h1);
      chk("sub_y", 0, 32'(ry[0]), 32'hE);
      chk("sub_ovf", 0, 32'(rovf[0]), 32'h0);
      chk("sub_err", 0, 32'(rerr[0]), 32'h0);
      chk("sub_op", 0, 32'(rop[0]), 32'h0);
      recv0();

      // SUB 7-(-1) overflows, then NAND
      send0(2'd0, 4'd7, 4'hF);
      tick();
      chk("subovf_y", 0, 32'(ry[0]), 32'h8);
      chk("subovf_ovf", 0, 32'(rovf[0]), 32'h1);
      recv0();
      chk("subovf_cnt", 0, 32'(ocnt[0]), 32'h1);
      send0(2'd1, 4'hC, 4'hA);
      tick();
      chk("nand_y", 0, 32'(ry[0]), 32'h7);
      chk("nand_ovf", 0, 32'(rovf[0]), 32'h0);
      recv0();
      chk("nand_cnt", 0, 32'(ocnt[0]), 32'h1);

      // ONES, then reserved opcode
      send0(2'd2, 4'hF, 4'hF);
      tick();
      chk("ones_y", 0, 32'(ry[0]), 32'h8);
      chk("ones_ovf", 0, 32'(rovf[0]), 32'h0);
      recv0();
      send0(2'd3, 4'h5, 4'h9);
      tick();
      chk("rsvd_y", 0, 32'(ry[0]), 32'h0);
      chk("rsvd_ovf", 0, 32'(rovf[0]), 32'h0);
      chk("rsvd_err", 0, 32'(rerr[0]), 32'h1);
      chk("rsvd_op", 0, 32'(rop[0]), 32'h3);
      recv0();
      chk("rsvd_sticky", 0, 32'(sticky[0]), 32'h1);

      // Back-pressure, then simultaneous result and command handshakes
      send0(2'd0, 4'd2, 4'd1);
      tick();
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_a     = 4'd6;
      cmd_b     = 4'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 0, 32'(rv[0]), 32'h1);
         chk("hold_y", 0, 32'(ry[0]), 32'h1);
         chk("hold_cmd_ready", 0, 32'(cmd_ready[0]), 32'h0);
      end
      tick();
      res_ready = 1'b1;
      @(negedge clk);
      chk("both_cmd_ready", 0, 32'(cmd_ready[0]), 32'h1);
      tick();
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      chk("both_valid_low", 0, 32'(rv[0]), 32'h0);
      chk("both_busy", 0, 32'(busy[0]), 32'h1);
      chk("both_o_a", 0, 32'(da[0]), 32'h6);
      chk("both_o_op", 0, 32'(dop[0]), 32'h1);
      tick();
      chk("both_y", 0, 32'(ry[0]), 32'hD);
      recv0();

      // Clear coinciding with an overflow handshake
      send0(2'd0, 4'd7, 4'hF);
      tick();
      clr_status = 1'b1;
      res_ready  = 1'b1;
      tick();
      clr_status = 1'b0;
      res_ready  = 1'b0;
      chk("clr_cnt", 0, 32'(ocnt[0]), 32'h1);
      chk("clr_sticky", 0, 32'(sticky[0]), 32'h0);

      // Saturation: over 300 overflow results
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_a     = 4'd7;
      cmd_b     = 4'hF;
      res_ready = 1'b1;
      repeat (640) tick();
      cmd_valid = 1'b0;
      repeat (5) tick();
      chk("sat_cnt", 0, 32'(ocnt[0]), 32'hFF);

      // Streaming on the SETTLE=3 instance
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cmd_valid = 1'b1;
      res_ready = 1'b1;
      n_res  = 0;
      last_t = -1;
      for (int t = 1; t <= 40; t++) begin
         cmd_op = 2'($urandom_range(0, 3));
         cmd_a  = 4'($urandom);
         cmd_b  = 4'($urandom);
         tick();
         if (rv[1]) begin
            if (last_t >= 0) chk("stream_interval", 1, 32'(t - last_t), 32'd4);
            last_t = t;
            n_res++;
         end
      end
      chk("stream_count", 1, 32'(n_res), 32'd10);
      cmd_valid = 1'b0;
      repeat (6) tick();

      // Reset during EXEC
      res_ready = 1'b0;
      send0(2'd0, 4'd2, 4'd1);
      rst = 1'b1;
      tick();
      chk("rst_valid", 0, 32'(rv[0]), 32'h0);
      chk("rst_busy", 0, 32'(busy[0]), 32'h0);
      chk("rst_o_a", 0, 32'(da[0]), 32'h0);
      chk("rst_o_op", 0, 32'(dop[0]), 32'h0);
      chk("rst_cnt", 0, 32'(ocnt[0]), 32'h0);
      chk("rst_sticky", 0, 32'(sticky[0]), 32'h0);
      chk("rst_cmd_ready", 0, 32'(cmd_ready[0]), 32'h1);
      rst = 1'b0;
      send0(2'd1, 4'd5, 4'd3);
      tick();
      chk("after_rst_y", 0, 32'(ry[0]), 32'hE);
      recv0();

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         cmd_valid  = ($urandom_range(0, 3) != 0);
         cmd_op     = 2'($urandom_range(0, 3));
         cmd_a      = 4'($urandom);
         cmd_b      = 4'($urandom);
         res_ready  = ($urandom_range(0, 3) != 0);
         clr_status = ($urandom_range(0, 49) == 0);
         rst        = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst        = 1'b0;
      cmd_valid  = 1'b0;
      clr_status = 1'b0;
      res_ready  = 1'b1;
      repeat (8) tick();
      summary();
      $finish;
   end
endmodule
